// File: rtl/router_output_drainer_pkg.sv
// rtl/router_output_drainer_pkg.sv - shared types and defaults for the router output drainer
package router_pkg;
    localparam int NUM_CH = 3;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_STARVE_LIMIT = 16;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } drain_state_t;

    function automatic chan_t next_chan(chan_t c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction
endpackage

// File: rtl/router_output_drainer_if.sv
// rtl/router_output_drainer_if.sv - router FIFO heads in, merged tagged byte stream out
interface router_output_drainer_if;
    import router_pkg::*;

    logic [NUM_CH-1:0] vld_in;
    logic [7:0]        data_in_0;
    logic [7:0]        data_in_1;
    logic [7:0]        data_in_2;
    logic [NUM_CH-1:0] read_enb;
    logic [7:0]        out_data;
    chan_t             out_chan;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  vld_in, data_in_0, data_in_1, data_in_2, out_ready,
        output read_enb, out_data, out_chan, out_valid
    );

    modport slave (
        output vld_in, data_in_0, data_in_1, data_in_2, out_ready,
        input  read_enb, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/router_output_drainer_rr_pick.sv
// rtl/router_output_drainer_rr_pick.sv - 3-way round-robin picker with burst hold
module rr_pick
    import router_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  chan_t             last,
    input  logic              hold_valid,
    input  chan_t             hold_idx,
    output logic              gnt_valid,
    output chan_t             gnt_idx
);
    chan_t c1, c2, c3;

    assign c1 = next_chan(last);
    assign c2 = next_chan(c1);
    assign c3 = next_chan(c2);

    // c3 equals last, so a lone requester that was just served still wins
    always_comb begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'd0;
        if (hold_valid && req[hold_idx]) begin
            gnt_idx = hold_idx;
        end else if (req[c1]) begin
            gnt_idx = c1;
        end else if (req[c2]) begin
            gnt_idx = c2;
        end else if (req[c3]) begin
            gnt_idx = c3;
        end else begin
            gnt_valid = 1'b0;
        end
    end
endmodule

// File: rtl/router_output_drainer.sv
// rtl/router_output_drainer.sv - merges three router FIFOs into one registered tagged stream
module router_output_drainer
    import router_pkg::*;
#(
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int STARVE_W     = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    router_output_drainer_if.master bus,
    output logic [NUM_CH-1:0]       starve,
    output logic                    busy
);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIMIT);

    drain_state_t         state;
    chan_t                cur;
    chan_t                last_grant;
    logic [BCW-1:0]       burst_cnt;
    logic [STARVE_W-1:0]  starve_cnt [NUM_CH];

    logic       load_en;
    logic       hold_valid;
    logic       gnt_valid;
    logic       pop;
    chan_t      gnt_idx;
    chan_t      scan_from;
    logic [7:0] win_data;

    assign load_en    = !bus.out_valid || bus.out_ready;
    assign hold_valid = (state == BURST) && (burst_cnt < BCW'(MAX_BURST));
    // while bursting, cur is the most recent grant, so the scan starts after it
    assign scan_from  = (state == BURST) ? cur : last_grant;

    rr_pick u_pick (
        .req        (bus.vld_in),
        .last       (scan_from),
        .hold_valid (hold_valid),
        .hold_idx   (cur),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign pop          = resetn && load_en && gnt_valid;
    assign bus.read_enb = pop ? (NUM_CH'(1) << gnt_idx) : '0;
    assign busy         = (state == BURST) || bus.out_valid;

    always_comb begin
        case (gnt_idx)
            2'd0:    win_data = bus.data_in_0;
            2'd1:    win_data = bus.data_in_1;
            default: win_data = bus.data_in_2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            cur           <= 2'd0;
            last_grant    <= 2'd2;
            burst_cnt     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_chan  <= 2'd0;
        end else if (load_en) begin
            if (gnt_valid) begin
                bus.out_data  <= win_data;
                bus.out_chan  <= gnt_idx;
                bus.out_valid <= 1'b1;
                state         <= BURST;
                cur           <= gnt_idx;
                if (state == BURST && gnt_idx == cur && hold_valid) begin
                    burst_cnt <= burst_cnt + BCW'(1);
                end else begin
                    burst_cnt <= BCW'(1);
                end
                if (state == BURST && gnt_idx != cur) begin
                    last_grant <= cur;
                end
            end else begin
                bus.out_valid <= 1'b0;
                burst_cnt     <= '0;
                state         <= IDLE;
                if (state == BURST) begin
                    last_grant <= cur;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                starve_cnt[c] <= '0;
            end
            starve <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.read_enb[c] || !bus.vld_in[c]) begin
                    starve_cnt[c] <= '0;
                end else if (starve_cnt[c] != LIM) begin
                    starve_cnt[c] <= starve_cnt[c] + STARVE_W'(1);
                end
                if (bus.read_enb[c]) begin
                    starve[c] <= 1'b0;
                end else if (bus.vld_in[c] && starve_cnt[c] >= LIM - STARVE_W'(1)) begin
                    starve[c] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_output_drainer.sv
// tb/tb_router_output_drainer.sv - randomized bench with queue-level drainer model
module tb_router_output_drainer;
    import router_pkg::*;

    localparam int MB = 2;
    localparam int SL = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] starve;
    logic       busy;

    always #5 clk = ~clk;

    router_output_drainer_if bus ();

    router_output_drainer #(
        .MAX_BURST    (MB),
        .STARVE_LIMIT (SL),
        .STARVE_W     (5)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .starve (starve),
        .busy   (busy)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // router FIFOs as seen by the drainer
    logic [7:0] q [3][$];

    bit         m_valid = 1'b0;
    bit         m_burst = 1'b0;
    int         m_last = 2;
    int         m_run = 0;
    logic [7:0] m_data = 8'h00;
    int         m_chan = 0;
    int         m_cnt [3];
    bit         m_starve [3];

    int         log_chan [$];
    logic [7:0] log_data [$];
    int         log_cyc [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // channel the drainer must pop this cycle, -1 for none
    function automatic int pick();
        if (!resetn) return -1;
        if (m_valid && !bus.out_ready) return -1;
        if (m_burst && q[m_last].size() > 0 && m_run < MB) return m_last;
        for (int k = 1; k <= 3; k++) begin
            if (q[(m_last + k) % 3].size() > 0) return (m_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        logic [7:0] d [3];
        for (int c = 0; c < 3; c++) begin
            if (q[c].size() > 0) d[c] = q[c][0];
            else d[c] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            bus.vld_in[c] = (q[c].size() > 0);
        end
        bus.data_in_0 = d[0];
        bus.data_in_1 = d[1];
        bus.data_in_2 = d[2];
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            drive_inputs();
        end
    endtask

    task automatic push(int c, logic [7:0] v);
        q[c].push_back(v);
        drive_inputs();
    endtask

    task automatic clear_log();
        log_chan.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        clear_log();
    endtask

    always @(posedge clk) begin : model
        int w;
        bit le;
        bit vld [3];
        cyc++;
        if (!resetn) begin
            m_valid = 1'b0;
            m_burst = 1'b0;
            m_last  = 2;
            m_run   = 0;
            m_data  = 8'h00;
            m_chan  = 0;
            for (int c = 0; c < 3; c++) begin
                m_cnt[c] = 0;
                m_starve[c] = 1'b0;
                q[c].delete();
            end
        end else begin
            w  = pick();
            le = !m_valid || bus.out_ready;
            for (int c = 0; c < 3; c++) vld[c] = (q[c].size() > 0);
            if (m_valid && bus.out_ready) begin
                log_chan.push_back(m_chan);
                log_data.push_back(m_data);
                log_cyc.push_back(cyc);
            end
            if (le) begin
                if (w >= 0) begin
                    m_run   = (m_burst && w == m_last && m_run < MB) ? m_run + 1 : 1;
                    m_data  = q[w].pop_front();
                    m_chan  = w;
                    m_valid = 1'b1;
                    m_last  = w;
                    m_burst = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_burst = 1'b0;
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (w == c || !vld[c]) m_cnt[c] = 0;
                else if (m_cnt[c] < SL) m_cnt[c]++;
                if (w == c) m_starve[c] = 1'b0;
                else if (m_cnt[c] == SL) m_starve[c] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic [2:0] exp_re;
        #2;
        if (chk_en) begin
            w = pick();
            exp_re = (w >= 0) ? (3'b001 << w) : 3'b000;
            check("read_enb", bus.read_enb, exp_re);
            check("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                check("out_data", bus.out_data, m_data);
                check("out_chan", bus.out_chan, m_chan);
            end
            check("starve", starve, {m_starve[2], m_starve[1], m_starve[0]});
            check("busy", busy, m_burst || m_valid);
        end
    end

    initial begin
        int n;
        int exp_rr [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
        int exp_tr [4]  = '{2, 0, 0, 0};

        bus.out_ready = 1'b0;
        bus.vld_in    = 3'b000;
        bus.data_in_0 = 8'h00;
        bus.data_in_1 = 8'h00;
        bus.data_in_2 = 8'h00;
        step(3);
        resetn = 1'b1;
        chk_en = 1'b1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_chan", bus.out_chan, 0);
        check("rst_starve", starve, 3'b000);
        check("rst_busy", busy, 0);

        // single channel, three words
        bus.out_ready = 1'b1;
        push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
        step(6);
        check("single_count", log_data.size(), 3);
        for (int i = 0; i < 3 && i < log_data.size(); i++) begin
            check("single_data", log_data[i], 8'hA1 + 8'(i));
            check("single_chan", log_chan[i], 0);
        end
        check("single_idle_valid", bus.out_valid, 0);
        check("single_idle_busy", busy, 0);

        // round robin with bursts of MB
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++) push(c, 8'h10 + 8'(c * 16) + 8'(i));
        step(16);
        check("rr_count", log_chan.size(), 12);
        for (int i = 0; i < 12 && i < log_chan.size(); i++) begin
            check("rr_chan", log_chan[i], exp_rr[i]);
            check("rr_data", log_data[i], 8'h10 + 8'(exp_rr[i] * 16) + 8'((i / 6) * 2 + (i % 2)));
        end

        // backpressure
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 3; i++) push(c, 8'h30 + 8'(c * 16) + 8'(i));
        step(2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_read_enb", bus.read_enb, 3'b000);
            step(1);
            check("bp_out_data", bus.out_data, 8'h31);
            check("bp_out_chan", bus.out_chan, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        step(12);
        check("bp_count", log_data.size(), 9);
        for (int c = 0; c < 3; c++) begin
            n = 0;
            for (int i = 0; i < log_data.size(); i++) begin
                if (log_chan[i] == c) begin
                    check("bp_order", log_data[i], 8'h30 + 8'(c * 16) + 8'(n));
                    n++;
                end
            end
            check("bp_per_chan", n, 3);
        end

        // starvation while the output is stalled
        do_reset();
        bus.out_ready = 1'b0;
        push(1, 8'h51); push(1, 8'h52);
        step(1);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("starve_rise", starve, (k >= SL) ? 3'b010 : 3'b000);
        end
        bus.out_ready = 1'b1;
        #1;
        check("starve_pop", bus.read_enb, 3'b010);
        step(1);
        check("starve_clear", starve, 3'b000);

        // burst truncation, no idle cycle between channels
        do_reset();
        bus.out_ready = 1'b1;
        push(2, 8'hC1);
        step(1);
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        step(6);
        check("trunc_count", log_chan.size(), 4);
        for (int i = 0; i < 4 && i < log_chan.size(); i++) begin
            check("trunc_chan", log_chan[i], exp_tr[i]);
            if (i > 0) check("trunc_gap", log_cyc[i] - log_cyc[i-1], 1);
        end

        // reset in the middle of a channel 1 burst
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 8'h61 + 8'(i));
        step(2);
        resetn = 1'b0;
        #1;
        check("midrst_read_enb", bus.read_enb, 3'b000);
        step(1);
        resetn = 1'b1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_starve", starve, 3'b000);
        check("midrst_busy", busy, 0);
        clear_log();
        push(0, 8'h71); push(1, 8'h72);
        step(4);
        check("midrst_count", log_chan.size(), 2);
        if (log_chan.size() == 2) begin
            check("midrst_first", log_chan[0], 0);
            check("midrst_second", log_chan[1], 1);
        end

        // randomized traffic with stall windows and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1);
            resetn = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 2) == 0 && q[c].size() < 4) q[c].push_back(8'($urandom));
            bus.out_ready = ((i % 200) < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            drive_inputs();
        end
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
